// File: rtl/teclado_pkg.sv
// Shared key codes and tracker state type for the keypad capture path.
// Code F is the scanner's "no key in this column" marker and never forms an event.
package teclado_pkg;

  localparam logic [3:0] K_NONE  = 4'hF;
  localparam logic [3:0] K_STAR  = 4'hE;
  localparam logic [3:0] K_ENTER = 4'hA;
  localparam logic [3:0] K_BACK  = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } estado_t;

  function automatic logic es_digito(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/captura_teclas_if.sv
// Bundle between the keypad scanner / application logic and captura_teclas.
// The master side drives the scanner code and consumes key events and operands.
interface captura_teclas_if #(
  parameter int NDIG = 3
) ();

  localparam int DW = $clog2(NDIG + 1);

  logic [3:0]        boton;
  logic [3:0]        tecla;
  logic              tecla_valid;
  logic [4*NDIG-1:0] entrada_bcd;
  logic [DW-1:0]     digitos;
  logic [4*NDIG-1:0] valor_bcd;
  logic              valor_valid;

  modport master (
    output boton,
    input  tecla,
    input  tecla_valid,
    input  entrada_bcd,
    input  digitos,
    input  valor_bcd,
    input  valor_valid
  );

  modport slave (
    input  boton,
    output tecla,
    output tecla_valid,
    output entrada_bcd,
    output digitos,
    output valor_bcd,
    output valor_valid
  );

endinterface

// File: rtl/captura_teclas_filtro.sv
// Key tracker: follows one candidate code across the column-multiplexed scan,
// debounces it and emits a single event per press, re-armed only by release.
module filtro_tecla
  import teclado_pkg::*;
#(
  parameter int HOLD_CYCLES = 256,
  parameter int DEB_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_boton,
  output logic [3:0] o_tecla,
  output logic       o_tecla_valid,
  output logic       o_acepta,
  output logic [3:0] o_tecla_next
);

  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_MAX  = DBW'(DEB_CYCLES - 1);

  estado_t        r_estado, w_estado_nxt;
  logic [3:0]     r_cand, w_cand_nxt;
  logic [HW-1:0]  r_hold, w_hold_nxt;
  logic [DBW-1:0] r_deb, w_deb_nxt;
  logic [3:0]     r_tecla;
  logic           r_tecla_valid;
  logic           w_nada;
  logic           w_acepta;

  assign w_nada = (i_boton == K_NONE);

  always_comb begin
    w_estado_nxt = r_estado;
    w_cand_nxt   = r_cand;
    w_hold_nxt   = r_hold;
    w_deb_nxt    = r_deb;
    w_acepta     = 1'b0;
    case (r_estado)
      IDLE: begin
        if (!w_nada) begin
          w_cand_nxt   = i_boton;
          w_hold_nxt   = HOLD_MAX;
          w_deb_nxt    = '0;
          w_estado_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (w_nada && (r_hold == '0)) begin
          w_estado_nxt = IDLE;
        end else if (!w_nada && (i_boton != r_cand)) begin
          w_cand_nxt = i_boton;
          w_hold_nxt = HOLD_MAX;
          w_deb_nxt  = '0;
        end else begin
          // Blank column slots still count toward the debounce time.
          w_hold_nxt = w_nada ? (r_hold - HW'(1)) : HOLD_MAX;
          if (r_deb == DEB_MAX) begin
            w_estado_nxt = PRESSED;
            w_acepta     = 1'b1;
          end else begin
            w_deb_nxt = r_deb + DBW'(1);
          end
        end
      end
      PRESSED: begin
        if (!w_nada) begin
          w_hold_nxt = HOLD_MAX;
        end else if (r_hold == '0) begin
          w_estado_nxt = IDLE;
        end else begin
          w_hold_nxt = r_hold - HW'(1);
        end
      end
      default: w_estado_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado      <= IDLE;
      r_cand        <= '0;
      r_hold        <= '0;
      r_deb         <= '0;
      r_tecla       <= '0;
      r_tecla_valid <= 1'b0;
    end else begin
      r_estado      <= w_estado_nxt;
      r_cand        <= w_cand_nxt;
      r_hold        <= w_hold_nxt;
      r_deb         <= w_deb_nxt;
      r_tecla_valid <= w_acepta;
      if (w_acepta) begin
        r_tecla <= r_cand;
      end
    end
  end

  assign o_tecla       = r_tecla;
  assign o_tecla_valid = r_tecla_valid;
  assign o_acepta      = w_acepta;
  assign o_tecla_next  = r_cand;

endmodule

// File: rtl/captura_teclas.sv
// Keypad capture top: debounced key events plus a BCD operand accumulator
// with clear ('*'), backspace (B) and commit (A).
module captura_teclas
  import teclado_pkg::*;
#(
  parameter int HOLD_CYCLES = 256,
  parameter int DEB_CYCLES  = 1000,
  parameter int NDIG        = 3
) (
  input  logic             clk,
  input  logic             rst,
  captura_teclas_if.slave  bus
);

  localparam int DW = $clog2(NDIG + 1);
  localparam logic [DW-1:0] MAX_DIG = DW'(NDIG);

  logic [3:0]        w_tecla;
  logic              w_tecla_valid;
  logic              w_acepta;
  logic [3:0]        w_tecla_next;

  logic [4*NDIG-1:0] r_entrada, w_entrada_nxt;
  logic [DW-1:0]     r_digitos, w_digitos_nxt;
  logic [4*NDIG-1:0] r_valor, w_valor_nxt;
  logic              r_valor_valid, w_valor_valid_nxt;
  logic [4*NDIG-1:0] w_shl;
  logic [4*NDIG-1:0] w_shr;

  filtro_tecla #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_filtro (
    .clk           (clk),
    .rst           (rst),
    .i_boton       (bus.boton),
    .o_tecla       (w_tecla),
    .o_tecla_valid (w_tecla_valid),
    .o_acepta      (w_acepta),
    .o_tecla_next  (w_tecla_next)
  );

  // The accumulator consumes the accept strobe so its registers update on the
  // same edge as tecla/tecla_valid and all outputs move together.
  assign w_shl[3:0]               = w_tecla_next;
  assign w_shr[4*NDIG-1:4*NDIG-4] = 4'h0;
  generate
    for (genvar gi = 1; gi < NDIG; gi++) begin : g_shl
      assign w_shl[4*gi +: 4] = r_entrada[4*(gi-1) +: 4];
    end
    for (genvar gi = 0; gi < NDIG - 1; gi++) begin : g_shr
      assign w_shr[4*gi +: 4] = r_entrada[4*(gi+1) +: 4];
    end
  endgenerate

  always_comb begin
    w_entrada_nxt     = r_entrada;
    w_digitos_nxt     = r_digitos;
    w_valor_nxt       = r_valor;
    w_valor_valid_nxt = 1'b0;
    if (w_acepta) begin
      if (es_digito(w_tecla_next)) begin
        if (r_digitos < MAX_DIG) begin
          w_entrada_nxt = w_shl;
          w_digitos_nxt = r_digitos + DW'(1);
        end
      end else begin
        case (w_tecla_next)
          K_STAR: begin
            w_entrada_nxt = '0;
            w_digitos_nxt = '0;
          end
          K_BACK: begin
            if (r_digitos != '0) begin
              w_entrada_nxt = w_shr;
              w_digitos_nxt = r_digitos - DW'(1);
            end
          end
          K_ENTER: begin
            if (r_digitos != '0) begin
              w_valor_nxt       = r_entrada;
              w_valor_valid_nxt = 1'b1;
              w_entrada_nxt     = '0;
              w_digitos_nxt     = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entrada     <= '0;
      r_digitos     <= '0;
      r_valor       <= '0;
      r_valor_valid <= 1'b0;
    end else begin
      r_entrada     <= w_entrada_nxt;
      r_digitos     <= w_digitos_nxt;
      r_valor       <= w_valor_nxt;
      r_valor_valid <= w_valor_valid_nxt;
    end
  end

  assign bus.tecla       = w_tecla;
  assign bus.tecla_valid = w_tecla_valid;
  assign bus.entrada_bcd = r_entrada;
  assign bus.digitos     = r_digitos;
  assign bus.valor_bcd   = r_valor;
  assign bus.valor_valid = r_valor_valid;

endmodule

// File: doc/captura_teclas.md
Name: captura_teclas

Overview:
- Sits directly downstream of the 4x4 matrix keypad scanner.
- Consumes the scanner's 4-bit `boton` code stream, where 4'hF means "no key in the current column".
- Turns that intermittent, column-multiplexed code into clean single-press events, then accumulates decimal digits into a BCD operand with clear, backspace and commit keys.
- Its outputs feed the application logic (display / arithmetic stages).

Parameters:
- HOLD_CYCLES, 256: cycles without seeing the tracked code before the key counts as released. Must exceed 4*SCAN_DIV, since the scanner shows a held key only during one column slot in four.
- DEB_CYCLES, 1000: cycles the same code must stay held (no hold timeout) before the press is accepted.
- NDIG, 3: maximum BCD digits in the operand.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- boton  in  4  scanner code: 0-9 digits, A/B/C/D letters, E = '*', F = none
- tecla  out  4  last accepted key code
- tecla_valid  out  1  one-cycle pulse when a press is accepted
- entrada_bcd  out  4*NDIG  live operand; digit 0 (least significant) in bits [3:0]
- digitos  out  $clog2(NDIG+1)  number of digits currently entered
- valor_bcd  out  4*NDIG  committed operand
- valor_valid  out  1  one-cycle pulse when valor_bcd is updated

Behaviour:
- Reset (async, active-high): all outputs and registers go to 0; FSM goes to IDLE. A reset asserted mid-debounce or mid-entry discards the pending key and the partial operand.
- Key code 4'hF is always "none". '#' (F) is therefore unusable and must never generate events.
- Tracker FSM, states IDLE, DEBOUNCE, PRESSED. Registers: `cand` (4 b), `hold_cnt`, `deb_cnt`.
- IDLE:
  - `boton` != F → `cand` <= `boton`, `hold_cnt` <= HOLD_CYCLES-1, `deb_cnt` <= 0, go to DEBOUNCE.
- DEBOUNCE:
  - `boton` == `cand`: reload `hold_cnt`.
  - `boton` == F: decrement `hold_cnt`.
  - `boton` is a different non-F code: restart DEBOUNCE with the new `cand` (counters reloaded).
  - `hold_cnt` reaches 0 while `boton` == F: go to IDLE with no event.
  - Otherwise `deb_cnt` increments every cycle. When it reaches DEB_CYCLES-1: go to PRESSED, `tecla` <= `cand`, `tecla_valid` = 1 on the following cycle.
- PRESSED:
  - Any non-F `boton` reloads `hold_cnt`; otherwise it decrements.
  - At 0, go to IDLE. This is the release.
  - No further event fires until release, so holding a key never auto-repeats.
  - A second key pressed while the first is held is ignored.
- Event latency: exactly DEB_CYCLES+1 cycles from the first non-F sample of a steadily held key to the `tecla_valid` pulse.
- Accumulator acts in the same cycle as `tecla_valid`:
  - Digit 0-9 with `digitos` < NDIG: shift `entrada_bcd` left one digit, insert the new digit at [3:0], `digitos`++.
  - Digit 0-9 with `digitos` == NDIG: ignored; `entrada_bcd` is unchanged.
  - E ('*'): clear `entrada_bcd` and `digitos` to 0.
  - B (backspace): shift right one digit (MSD gets 0), `digitos`--. Ignored when `digitos` == 0.
  - A (commit) with `digitos` > 0: `valor_bcd` <= `entrada_bcd`, `valor_valid` = 1 for one cycle (same cycle as `tecla_valid`), then clear the entry.
  - A with `digitos` == 0: ignored, no pulse.
  - C, D: reported on `tecla`/`tecla_valid`, no accumulator effect.
- `valor_bcd` holds its value until the next commit or reset.

Decomposition:
- Shared package `teclado_pkg`:
  - key constants K_NONE=4'hF, K_STAR=4'hE, K_ENTER=4'hA, K_BACK=4'hB.
  - tracker state enum {IDLE, DEBOUNCE, PRESSED}.
- One natural sub-module `filtro_tecla`, containing the tracker FSM plus the hold and debounce counters; it outputs `tecla`/`tecla_valid`.
- The accumulator stays in the top module.

Test Plan:
- Model the scanner with SCAN_DIV=50 (key visible 50 of every 200 cycles), DEB_CYCLES=1000, HOLD_CYCLES=256:
  - hold '5' for 3000 cycles → exactly one `tecla_valid` with `tecla`=5, `digitos`=1, `entrada_bcd`=12'h005.
- Bounce: '7' visible for 300 cycles, then absent for 300 → no event, FSM back to IDLE. Then a steady '7' → one event.
- Keys 1,2,3,4, then A → `entrada_bcd` 12'h001→012→123, the '4' is ignored, `valor_valid` pulses once with `valor_bcd`=12'h123, `digitos` returns to 0.
- Keys 9, 8, B, 6, then '*' → 12'h009→098→009→096→000.
- A with an empty entry → no `valor_valid`, but `tecla_valid` still pulses with `tecla`=A.
- Hold '2', then during DEBOUNCE switch to '3' → single event with `tecla`=3. Separately, assert `rst` during PRESSED → all outputs 0 immediately; no event after `rst` deasserts while the key is still held until DEB_CYCLES elapses again.
